div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for the EX stage. Drives the DivReadyE side
//  of the divide-stall handshake: the hazard unit stalls F/D/E while
//  StartDivE & ~DivReadyE. Computes signed or unsigned 32/32 divide.
//  Result goes to HI (remainder) and LO (quotient) on the normal HI/LO write path.
// PARAMETERS
//  WIDTH      32   operand width; result is 2*WIDTH
//  CNT_W      6    iteration counter width; must hold WIDTH
// PORTS
//  clk         in   1        rising-edge clock
//  resetn      in   1        asynchronous, active-low reset
//  StartDivE   in   1        level; high while a div/divu occupies EX
//  SignedDivE  in   1        1 = div (signed), 0 = divu
//  AnnulDivE   in   1        abort current divide (pipeline flush/exception)
//  SrcAE       in   WIDTH    dividend, sampled only on accept
//  SrcBE       in   WIDTH    divisor, sampled only on accept
//  DivResultE  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
//  DivReadyE   out  1        one-cycle pulse: DivResultE valid this cycle
//  DivBusyE    out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; DivResultE=0; DivReadyE=0; DivBusyE=0; counter=0.
//  FSM states: IDLE, BYZERO, ON, END.
//   IDLE  : StartDivE&~AnnulDivE -> latch operands, sign flag. Divisor==0 -> BYZERO,
//           else -> ON with counter=0.
//   BYZERO: quotient=all ones, remainder=dividend (raw SrcAE) -> END.
//   ON    : one restoring step/cycle on {rem,quot} shift register. Counter 0..WIDTH-1.
//           After step WIDTH-1, apply sign fix-up -> END.
//   END   : DivReadyE=1 for exactly this cycle; DivResultE holds the result -> IDLE
//           unconditionally.
//  END->IDLE is unconditional because EX advances on the same edge. StartDivE high in
//   the next IDLE cycle is a new instruction and is accepted (back-to-back divides).
//  Latency: accept edge at cycle N; ON at N+1..N+32; DivReadyE at N+33.
//   Divide-by-zero: DivReadyE at N+2.
//  Signed: divide |A| by |B| unsigned. Negate quotient if sign(A)^sign(B).
//   Negate remainder if sign(A). Operands taken from the latched copies, never live ports.
//  0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0 (wraps, no trap).
//  Unsigned: no fix-up; SignedDivE is ignored after accept.
//  AnnulDivE high in any state: -> IDLE next edge, no DivReadyE pulse.
//   DivResultE keeps its previous value.
//  StartDivE dropping while ON (no annul): divide completes; the pulse is still generated.
//  DivResultE changes only on entry to END; stable from then until the next END.
//  DivReadyE never high in two consecutive cycles.
// STRUCTURE
//  Shared header (div_defs.vh): state encodings DIV_IDLE/BYZERO/ON/END (2 bits),
//   DIV_WIDTH.
//  Sub-module div_step: combinational trial subtract of {rem,next bit} - divisor.
//   Returns new partial remainder and quotient bit. Instantiated once.
//  Top: FSM, counter, operand/sign registers, abs/negate logic, result register.
// TESTING
//  Unsigned: SrcAE=100, SrcBE=7, divu -> pulse at start+33; HI=2, LO=14.
//  Signed: SrcAE=-7 (0xFFFFFFF9), SrcBE=2 -> LO=0xFFFFFFFD (-3),
//   HI=0xFFFFFFFF (-1).
//  Zero divisor: SrcAE=0x1234, SrcBE=0 -> pulse at start+2;
//   LO=0xFFFFFFFF, HI=0x1234.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  Annul: AnnulDivE at start+10 -> IDLE at start+11; no pulse for 40 cycles;
//   DivResultE unchanged.
//  Back-to-back: 9/3 then 10/4, StartDivE held high across the pulse ->
//   second pulse 34 cycles after the first; results {0,3} then {2,2}.
//   Reset mid-ON -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage iterative divider.
// State codes are plain 2-bit constants so older logic can decode them.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_BYZERO = 2'd1;
  localparam logic [1:0] DIV_ON     = 2'd2;
  localparam logic [1:0] DIV_END    = 2'd3;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if non-negative.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, bit_in};
  assign trial   = shifted - {1'b0, dvsr};

  // rem < dvsr holds, so a borrow shows up in the top bit
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for EX; drives the divide-stall
// handshake and returns {remainder, quotient} for HI/LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               StartDivE,
  input  logic               SignedDivE,
  input  logic               AnnulDivE,
  input  logic [WIDTH-1:0]   SrcAE,
  input  logic [WIDTH-1:0]   SrcBE,
  output logic [2*WIDTH-1:0] DivResultE,
  output logic               DivReadyE,
  output logic               DivBusyE
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_last;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             a_neg;
  logic             b_neg;
  logic             last;

  div_unit_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (rem),
    .bit_in   (quot[WIDTH-1]),
    .dvsr     (dvsr),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  assign a_neg = SignedDivE & SrcAE[WIDTH-1];
  assign b_neg = SignedDivE & SrcBE[WIDTH-1];
  assign a_abs = a_neg ? -SrcAE : SrcAE;
  assign b_abs = b_neg ? -SrcBE : SrcBE;

  assign q_last = {quot[WIDTH-2:0], q_bit};
  assign q_fix  = neg_q ? -q_last : q_last;
  assign r_fix  = neg_r ? -rem_nxt : rem_nxt;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  assign DivReadyE = (state == DIV_END);
  assign DivBusyE  = (state != DIV_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quot       <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      DivResultE <= '0;
    end else if (AnnulDivE) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (StartDivE) begin
            cnt   <= '0;
            rem   <= '0;
            dvsr  <= b_abs;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            // zero divisor keeps the raw dividend for HI
            if (SrcBE == '0) begin
              quot  <= SrcAE;
              state <= DIV_BYZERO;
            end else begin
              quot  <= a_abs;
              state <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          DivResultE <= {quot, {WIDTH{1'b1}}};
          state      <= DIV_END;
        end
        DIV_ON: begin
          rem  <= rem_nxt;
          quot <= q_last;
          cnt  <= cnt + 1'b1;
          if (last) begin
            DivResultE <= {r_fix, q_fix};
            state      <= DIV_END;
          end
        end
        DIV_END: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus
// random operands against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        StartDivE = 1'b0;
  logic        SignedDivE = 1'b0;
  logic        AnnulDivE = 1'b0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic [63:0] DivResultE;
  logic        DivReadyE;
  logic        DivBusyE;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .StartDivE  (StartDivE),
    .SignedDivE (SignedDivE),
    .AnnulDivE  (AnnulDivE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .DivResultE (DivResultE),
    .DivReadyE  (DivReadyE),
    .DivBusyE   (DivBusyE)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic sgn);
    @(negedge clk);
    StartDivE  = 1'b1;
    SignedDivE = sgn;
    SrcAE      = a;
    SrcBE      = b;
    AnnulDivE  = 1'b0;
  endtask

  // Counts cycles after the accept edge until the ready pulse.
  task automatic wait_pulse(input int scr, input bit drop,
                            output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1)
        chk("hold", DivResultE, last_res);
      if (k == scr) begin
        chk("busy", {63'd0, DivBusyE}, 64'd1);
        SrcAE      = $urandom;
        SrcBE      = $urandom;
        SignedDivE = ~SignedDivE;
        if (drop) StartDivE = 1'b0;
      end
    end while (!DivReadyE && k < 50);
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic sgn,
                        input bit drop,
                        input string tag);
    logic [63:0] exp;
    int          k;
    int          lat;
    exp = ref_div(a, b, sgn);
    lat = (b == 32'd0) ? 2 : 33;
    launch(a, b, sgn);
    wait_pulse(1, drop, k);
    chk({tag, "_lat"}, 64'(k), 64'(lat));
    chk({tag, "_res"}, DivResultE, exp);
    StartDivE = 1'b0;
    last_res  = exp;
    @(negedge clk);
    chk({tag, "_pulse1"}, {63'd0, DivReadyE}, 64'd0);
  endtask

  initial begin
    int k;
    int k2;
    int cnt;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;

    #12;
    chk("rst_out", {DivResultE[31:0], 30'd0, DivReadyE, DivBusyE},
        64'd0);
    chk("rst_res_hi", {32'd0, DivResultE[63:32]}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0, "divu");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "sdiv");
    run_op(32'h0000_1234, 32'd0, 1'b1, 1'b0, "byzero");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "ovf");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, "drop");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "negb");

    // annul partway through
    launch(32'd1000, 32'd3, 1'b0);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
    end
    AnnulDivE = 1'b1;
    @(negedge clk);
    chk("annul_idle", {63'd0, DivBusyE}, 64'd0);
    AnnulDivE = 1'b0;
    StartDivE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DivReadyE) cnt++;
    end
    chk("annul_nopulse", 64'(cnt), 64'd0);
    chk("annul_hold", DivResultE, last_res);

    // back-to-back with StartDivE held high over the pulse
    launch(32'd9, 32'd3, 1'b0);
    wait_pulse(1, 1'b0, k);
    chk("b2b1_res", DivResultE, 64'h0000_0000_0000_0003);
    last_res   = 64'h0000_0000_0000_0003;
    SrcAE      = 32'd10;
    SrcBE      = 32'd4;
    SignedDivE = 1'b0;
    wait_pulse(3, 1'b0, k2);
    chk("b2b_gap", 64'(k2), 64'd34);
    chk("b2b2_res", DivResultE, 64'h0000_0002_0000_0002);
    StartDivE = 1'b0;
    last_res  = 64'h0000_0002_0000_0002;
    @(negedge clk);

    // reset mid-divide
    launch(32'd555, 32'd11, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst", {DivResultE[31:0], 30'd0, DivReadyE, DivBusyE},
        64'd0);
    chk("midrst_hi", {32'd0, DivResultE[63:32]}, 64'd0);
    @(negedge clk);
    StartDivE = 1'b0;
    resetn    = 1'b1;
    last_res  = '0;

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a ^ 32'h0000_0001;
        default: b = $urandom;
      endcase
      if (i == 0) a = 32'h8000_0000;
      run_op(a, b, sgn, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
